// File: rtl/mm_iddmm_pkg.sv
// Shared types and default sizing for the IDDMM host initiator.
// Defaults track the multiplier's word size and operand length.
package mm_iddmm_pkg;

  localparam int MM_K       = 128;
  localparam int MM_N       = 32;
  localparam int MM_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_START,
    S_LOAD_X,
    S_WAIT_RES,
    S_DONE
  } mm_host_state_e;

endpackage

// File: rtl/mm_word_ser.sv
// Holds one K*N-bit operand and emits it as K-bit words, low first.
// The word index parks on the last word until the next load.
module mm_word_ser
  import mm_iddmm_pkg::*;
#(
  parameter int K = MM_K,
  parameter int N = MM_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [K*N-1:0] data,
  input  logic           en,
  output logic [K-1:0]   word,
  output logic           valid,
  output logic           last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [K*N-1:0] buf_q;
  logic [IW-1:0]  idx_q;
  logic           at_end;

  assign at_end = (idx_q == IW'(N - 1));
  assign valid  = en;
  assign last   = en && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      buf_q <= data;
      idx_q <= '0;
    end else if (en && !at_end) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  always_comb begin
    word = '0;
    if (en) begin
      for (int j = 0; j < N; j++) begin
        if (idx_q == IW'(j)) begin
          word = buf_q[j*K +: K];
        end
      end
    end
  end

endmodule

// File: rtl/mm_iddmm_host.sv
// Host initiator: streams y then x into the IDDMM multiplier, pulses
// start, reassembles N result words and guards the wait with a watchdog.
module mm_iddmm_host
  import mm_iddmm_pkg::*;
#(
  parameter int K       = MM_K,
  parameter int N       = MM_N,
  parameter int TIMEOUT = MM_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [K*N-1:0] req_x,
  input  logic [K*N-1:0] req_y,
  output logic           mm_start,
  output logic [K-1:0]   mm_x,
  output logic           mm_x_valid,
  output logic [K-1:0]   mm_y,
  output logic           mm_y_valid,
  input  logic [K-1:0]   mm_result,
  input  logic           mm_valid,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [K*N-1:0] rsp_data,
  output logic           rsp_err,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  mm_host_state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [WW-1:0] wd_q;
  logic          accept;
  logic          y_en, x_en;
  logic          y_last, x_last;
  logic          got_word, last_word, wd_exp;

  // Gated by rst so the requester never sees ready during reset.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign got_word  = (state_q == S_WAIT_RES) && mm_valid;
  assign last_word = got_word && (cnt_q == CW'(N - 1));
  assign wd_exp    = (state_q == S_WAIT_RES) && (wd_q == WW'(TIMEOUT - 1));

  mm_word_ser #(.K(K), .N(N)) u_ser_y (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .data  (req_y),
    .en    (y_en),
    .word  (mm_y),
    .valid (mm_y_valid),
    .last  (y_last)
  );

  mm_word_ser #(.K(K), .N(N)) u_ser_x (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .data  (req_x),
    .en    (x_en),
    .word  (mm_x),
    .valid (mm_x_valid),
    .last  (x_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    y_en      = 1'b0;
    x_en      = 1'b0;
    mm_start  = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        y_en = 1'b1;
        if (y_last) state_d = S_START;
      end
      S_START: begin
        mm_start = 1'b1;
        state_d  = S_LOAD_X;
      end
      S_LOAD_X: begin
        x_en = 1'b1;
        if (x_last) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (last_word || wd_exp) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      cnt_q    <= '0;
      wd_q     <= '0;
    end else begin
      if (accept) begin
        rsp_data <= '0;
        rsp_err  <= 1'b0;
        cnt_q    <= '0;
        wd_q     <= '0;
      end
      if (got_word) begin
        for (int j = 0; j < N; j++) begin
          if (cnt_q == CW'(j)) rsp_data[j*K +: K] <= mm_result;
        end
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_WAIT_RES) begin
        wd_q <= wd_q + 1'b1;
        // A final word landing on the expiry cycle still completes cleanly.
        if (wd_exp && !last_word) rsp_err <= 1'b1;
      end
    end
  end

endmodule
